multi_memory_responder: RTL and testbench

//  Unified instruction/data memory serving the multicycle MIPS control path (IorD-muxed address).

---
 rtl/multi_memory_responder.sv | 140 ++++++++++++++
 tb/tb_multi_memory_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_memory_responder.sv
// Purpose : unified instruction/data word memory for a multicycle MIPS datapath, with a
//           registered multi-stage read, write-first forwarding and a read-valid qualifier.
// Latency : ReadData and RdValid follow the sampled Adr by RD_LAT cycles; AdrErr by 1 cycle.
// Backpressure: none; one access is accepted every cycle, and RdValid tells the consumer when
//               ReadData is trustworthy.
//
// Ports:
//   clk       in   system clock, all logic on posedge
//   rstn      in   synchronous active-low reset (clears pipeline/flags, not RAM contents)
//   Adr       in   32-bit byte address; word index is Adr[ADDR_W+1:2]
//   WD        in   store data
//   MemWrite  in   level write strobe, sampled every posedge
//   ReadData  out  last read-pipeline stage
//   RdValid   out  ReadData matches the current address and the current memory contents
//   AdrErr    out  previous-cycle access was out of range (or misaligned, see below)
//
// Optional feature: define MEM_ALIGN_CHECK_EN to treat Adr[1:0]!=0 as an error
// (the write is dropped, the read returns 0 and RdValid stays low).
// Without it, the low address bits are ignored and the containing word is accessed.
module multi_memory_responder #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [31:0]       Adr,
    input  logic [DATA_W-1:0] WD,
    input  logic              MemWrite,
    output logic [DATA_W-1:0] ReadData,
    output logic              RdValid,
    output logic              AdrErr
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // One read-pipeline stage: the data plus the tags needed to judge it later.
    typedef struct packed {
        logic [DATA_W-1:0] dat;
        logic [ADDR_W-1:0] widx;
        logic              ok;     // access was legal (in range, aligned if checked)
        logic              stale;  // a later write hit this word while in flight
    } stage_t;

    logic [DATA_W-1:0] mem [DEPTH];

    stage_t            pipe     [RD_LAT];
    stage_t            pipe_nxt [RD_LAT];
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [29:0]       prev_wadr;

    logic [ADDR_W-1:0] widx;
    logic              oor;
    logic              misalign;
    logic              acc_ok;
    logic              wr_en;
    logic [DATA_W-1:0] rd_dat;
    logic              rd_vld_nxt;

    assign widx = Adr[ADDR_W+1:2];
    assign oor  = |Adr[31:ADDR_W+2];

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = |Adr[1:0];
`else
    logic unused_lo;
    assign unused_lo = ^Adr[1:0];
    assign misalign  = 1'b0;
`endif

    assign acc_ok = !oor && !misalign;
    assign wr_en  = rstn && MemWrite && acc_ok;
    assign rd_dat = acc_ok ? mem[widx] : '0;

    // RAM array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[widx] <= WD;
        end
    end

    always_comb begin
        // Stage 0 is write-first: a same-cycle store is what the read sees.
        pipe_nxt[0].dat   = wr_en ? WD : rd_dat;
        pipe_nxt[0].widx  = widx;
        pipe_nxt[0].ok    = acc_ok;
        pipe_nxt[0].stale = 1'b0;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_nxt[i]       = pipe[i-1];
            pipe_nxt[i].stale = pipe[i-1].stale
                              | (wr_en && pipe[i-1].ok && (pipe[i-1].widx == widx));
        end
    end

    // Stability counter: restarts on a new word address or on a store to the
    // addressed word, otherwise climbs and saturates at RD_LAT.
    always_comb begin
        cnt_nxt = cnt;
        if ((Adr[31:2] != prev_wadr) || wr_en) begin
            cnt_nxt = CNT_ONE;
        end else if (cnt >= CNT_MAX) begin
            cnt_nxt = CNT_MAX;
        end else begin
            cnt_nxt = cnt + CNT_ONE;
        end
    end

    // Evaluated on next-state values so RdValid lines up with the ReadData it qualifies.
    assign rd_vld_nxt = (cnt_nxt == CNT_MAX)
                     && !pipe_nxt[RD_LAT-1].stale
                     && pipe_nxt[RD_LAT-1].ok
                     && acc_ok;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe[i] <= '0;
            end
            cnt       <= '0;
            prev_wadr <= '0;
            RdValid   <= 1'b0;
            AdrErr    <= 1'b0;
        end else begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe[i] <= pipe_nxt[i];
            end
            cnt       <= cnt_nxt;
            prev_wadr <= Adr[31:2];
            RdValid   <= rd_vld_nxt;
            AdrErr    <= !acc_ok;
        end
    end

    assign ReadData = pipe[RD_LAT-1].dat;

endmodule

// File: tb/tb_multi_memory_responder.sv
// Bench for multi_memory_responder (default parameters): directed vector table for the
// documented scenarios, then random traffic against a cycle-window reference model.
module tb_multi_memory_responder;

    localparam int AW  = 10;
    localparam int LAT = 2;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit          ALIGN  = 1'b1;
    localparam logic        E19    = 1'b1;
    localparam logic [31:0] RD20   = 32'h0000_0000;
    localparam logic        V20    = 1'b0;
    localparam logic [31:0] RD21   = 32'h1234_5678;
`else
    localparam bit          ALIGN  = 1'b0;
    localparam logic        E19    = 1'b0;
    localparam logic [31:0] RD20   = 32'hFFFF_FFFF;
    localparam logic        V20    = 1'b1;
    localparam logic [31:0] RD21   = 32'hFFFF_FFFF;
`endif

    logic        clk;
    logic        rstn;
    logic [31:0] Adr;
    logic [31:0] WD;
    logic        MemWrite;
    logic [31:0] ReadData;
    logic        RdValid;
    logic        AdrErr;

    multi_memory_responder #(.ADDR_W(AW), .DATA_W(32), .RD_LAT(LAT)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .Adr      (Adr),
        .WD       (WD),
        .MemWrite (MemWrite),
        .ReadData (ReadData),
        .RdValid  (RdValid),
        .AdrErr   (AdrErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain word array plus a history of the last LAT clock edges.
    logic [31:0] mdl_mem [1 << AW];
    logic        h_rst  [LAT];
    logic [29:0] h_wadr [LAT];
    logic        h_err  [LAT];
    logic [31:0] h_rd   [LAT];
    logic        h_wr   [LAT];
    logic [31:0] exp_rd;
    logic        exp_vld;
    logic        exp_err;

    task automatic model_edge(input logic r, input logic [31:0] a, input logic [31:0] d,
                              input logic w);
        logic        e;
        logic        wr;
        logic [31:0] rv;
        logic        all_run;
        logic        same;
        logic        no_wr;
        e = |a[31:AW+2];
        if (ALIGN && (a[1:0] != 2'b00)) e = 1'b1;
        wr = r && w && !e;
        rv = e ? 32'h0 : (wr ? d : mdl_mem[a[AW+1:2]]);
        if (wr) mdl_mem[a[AW+1:2]] = d;
        for (int i = LAT - 1; i > 0; i--) begin
            h_rst[i]  = h_rst[i-1];
            h_wadr[i] = h_wadr[i-1];
            h_err[i]  = h_err[i-1];
            h_rd[i]   = h_rd[i-1];
            h_wr[i]   = h_wr[i-1];
        end
        h_rst[0]  = r;
        h_wadr[0] = a[31:2];
        h_err[0]  = e;
        h_rd[0]   = rv;
        h_wr[0]   = wr;
        // Data is the read issued LAT-1 edges ago, unless a reset edge fell inside the window.
        // Valid needs a full reset-free window at one word address, no store after the
        // oldest edge, and both the delivered read and the current access legal.
        all_run = 1'b1;
        same    = 1'b1;
        no_wr   = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            if (!h_rst[i]) all_run = 1'b0;
            if (h_wadr[i] != h_wadr[0]) same = 1'b0;
        end
        for (int i = 0; i < LAT - 1; i++) begin
            if (h_wr[i]) no_wr = 1'b0;
        end
        exp_err = r && e;
        exp_rd  = all_run ? h_rd[LAT-1] : 32'h0;
        exp_vld = all_run && same && no_wr && !h_err[0] && !h_err[LAT-1];
    endtask

    task automatic step(input logic r, input logic [31:0] a, input logic [31:0] d,
                        input logic w);
        rstn     = r;
        Adr      = a;
        WD       = d;
        MemWrite = w;
        @(posedge clk);
        model_edge(r, a, d, w);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
        end
    endtask

    typedef struct {
        logic        rstn;
        logic [31:0] adr;
        logic [31:0] wd;
        logic        we;
        logic        chk;
        logic [31:0] rd;
        logic        vld;
        logic        err;
    } vec_t;

    vec_t tbl [26];

    initial begin
        logic [31:0] cur;
        logic [31:0] a;
        logic        w;
        logic        r;

        for (int i = 0; i < LAT; i++) begin
            h_rst[i] = 1'b0; h_wadr[i] = '0; h_err[i] = 1'b0; h_rd[i] = '0; h_wr[i] = 1'b0;
        end

        // Expected outputs are those seen just after the clock edge that sampled the row.
        tbl[0]  = '{1'b1, 32'h0000_0000, 32'h2010_0005, 1'b1, 1'b0, 32'h0,          1'b0, 1'b0};
        tbl[1]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 1'b1, 32'h0,          1'b0, 1'b0};
        tbl[2]  = '{1'b1, 32'h0000_0000, 32'h0,         1'b0, 1'b1, 32'h0,          1'b0, 1'b0};
        tbl[3]  = '{1'b1, 32'h0000_0000, 32'h0,         1'b0, 1'b1, 32'h2010_0005,  1'b1, 1'b0};
        tbl[4]  = '{1'b1, 32'h0000_0000, 32'h0,         1'b0, 1'b1, 32'h2010_0005,  1'b1, 1'b0};
        tbl[5]  = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h2010_0005,  1'b0, 1'b0};
        tbl[6]  = '{1'b1, 32'h0000_0040, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF,  1'b1, 1'b0};
        tbl[7]  = '{1'b1, 32'h0000_0040, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF,  1'b1, 1'b0};
        tbl[8]  = '{1'b1, 32'h0000_0040, 32'h1234_5678, 1'b1, 1'b1, 32'hDEAD_BEEF,  1'b0, 1'b0};
        tbl[9]  = '{1'b1, 32'h0000_0040, 32'h0,         1'b0, 1'b1, 32'h1234_5678,  1'b1, 1'b0};
        tbl[10] = '{1'b1, 32'h0000_0040, 32'h0,         1'b0, 1'b1, 32'h1234_5678,  1'b1, 1'b0};
        tbl[11] = '{1'b1, 32'h0000_1000, 32'h5555_5555, 1'b1, 1'b1, 32'h1234_5678,  1'b0, 1'b1};
        tbl[12] = '{1'b1, 32'h0000_1000, 32'h0,         1'b0, 1'b1, 32'h0,          1'b0, 1'b1};
        tbl[13] = '{1'b1, 32'h0000_0000, 32'h0,         1'b0, 1'b1, 32'h0,          1'b0, 1'b0};
        tbl[14] = '{1'b1, 32'h0000_0000, 32'h0,         1'b0, 1'b1, 32'h2010_0005,  1'b1, 1'b0};
        tbl[15] = '{1'b1, 32'h0000_0004, 32'h0,         1'b0, 1'b1, 32'h2010_0005,  1'b0, 1'b0};
        tbl[16] = '{1'b1, 32'h0000_0000, 32'h0,         1'b0, 1'b1, 32'hC0DE_0001,  1'b0, 1'b0};
        tbl[17] = '{1'b1, 32'h0000_0004, 32'h0,         1'b0, 1'b1, 32'h2010_0005,  1'b0, 1'b0};
        tbl[18] = '{1'b1, 32'h0000_0000, 32'h0,         1'b0, 1'b1, 32'hC0DE_0001,  1'b0, 1'b0};
        tbl[19] = '{1'b1, 32'h0000_0042, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h2010_0005,  1'b0, E19};
        tbl[20] = '{1'b1, 32'h0000_0040, 32'h0,         1'b0, 1'b1, RD20,           V20,  1'b0};
        tbl[21] = '{1'b1, 32'h0000_0040, 32'h0,         1'b0, 1'b1, RD21,           1'b1, 1'b0};
        tbl[22] = '{1'b1, 32'h0000_0040, 32'h0,         1'b0, 1'b1, RD21,           1'b1, 1'b0};
        tbl[23] = '{1'b0, 32'h0000_0040, 32'h0,         1'b0, 1'b1, 32'h0,          1'b0, 1'b0};
        tbl[24] = '{1'b1, 32'h0000_0040, 32'h0,         1'b0, 1'b1, 32'h0,          1'b0, 1'b0};
        tbl[25] = '{1'b1, 32'h0000_0040, 32'h0,         1'b0, 1'b1, RD21,           1'b1, 1'b0};

        rstn = 1'b0; Adr = '0; WD = '0; MemWrite = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b0);

        // Give every word a known value through the write port.
        for (int i = 0; i < (1 << AW); i++) begin
            step(1'b1, 32'(i) << 2, 32'hC0DE_0000 | 32'(i), 1'b1);
        end

        for (int i = 0; i < 26; i++) begin
            step(tbl[i].rstn, tbl[i].adr, tbl[i].wd, tbl[i].we);
            if (tbl[i].chk) begin
                check("tbl_ReadData", i, ReadData, tbl[i].rd);
                check("tbl_RdValid",  i, {31'b0, RdValid}, {31'b0, tbl[i].vld});
                check("tbl_AdrErr",   i, {31'b0, AdrErr},  {31'b0, tbl[i].err});
            end
        end

        // Random traffic: mostly held addresses over a small word pool so stores
        // frequently collide with reads in flight.
        cur = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) >= 55) begin
                if ($urandom_range(0, 19) == 0) begin
                    a = (32'h1 << $urandom_range(AW + 2, 31)) | (32'($urandom_range(0, 1023)) << 2);
                end else begin
                    a = 32'($urandom_range(0, 15)) << 2;
                    if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
                end
                cur = a;
            end
            w = ($urandom_range(0, 99) < 15);
            r = ($urandom_range(0, 99) >= 2);
            step(r, cur, $urandom, w);
            check("rnd_ReadData", n, ReadData, exp_rd);
            check("rnd_RdValid",  n, {31'b0, RdValid}, {31'b0, exp_vld});
            check("rnd_AdrErr",   n, {31'b0, AdrErr},  {31'b0, exp_err});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
